// File: rtl/clk_mon.sv
// clk_mon: measures the period of a slow asynchronous clock and flags frequency errors and clock loss
//
// Ports:
//   clk        in   system clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   mon_clk    in   slow clock under test, asynchronous to clk
//   clr        in   single-cycle pulse clearing the sticky flags
//   period     out  last measured mon_clk period in clk cycles
//   period_vld out  one-cycle pulse when period updates
//   freq_ok    out  last period within EXP_CYC +/- TOL and clock not lost
//   freq_err   out  sticky: an out-of-range period was measured
//   clk_lost   out  sticky: LOSS_CYC cycles passed without a mon_clk edge
//   irq        out  registered freq_err | clk_lost, present only with CLK_MON_IRQ_EN defined
module clk_mon #(
    parameter int EXP_CYC  = 1024,
    parameter int TOL      = 8,
    parameter int LOSS_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mon_clk,
    input  logic        clr,
    output logic [12:0] period,
    output logic        period_vld,
    output logic        freq_ok,
    output logic        freq_err,
`ifdef CLK_MON_IRQ_EN
    output logic        irq,
`endif
    output logic        clk_lost
);
    typedef enum logic [1:0] {IDLE, MEAS, LOST} state_t;

    localparam logic [12:0]        LOSS = 13'(LOSS_CYC);
    localparam logic signed [13:0] EXP  = 14'(EXP_CYC);
    localparam logic signed [13:0] TOLS = 14'(TOL);

    state_t             st, nxt;
    logic               s1, s2, s3;
    logic               rise, rpt, lose, in_rng;
    logic [12:0]        cnt;
    logic signed [13:0] diff;

    assign rise   = s2 & ~s3;
    assign diff   = $signed({1'b0, cnt}) - EXP;
    assign in_rng = (diff <= TOLS) && (diff >= -TOLS);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE, LOST: nxt = rise ? MEAS : st;
            MEAS:       nxt = (!rise && cnt == LOSS) ? LOST : MEAS;
            default:    nxt = IDLE;
        endcase
    end

    // A rise coinciding with saturation takes the measurement path.
    always_comb begin
        rpt  = (st == MEAS) && rise;
        lose = (st == MEAS) && !rise && (cnt == LOSS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            freq_ok    <= 1'b0;
            freq_err   <= 1'b0;
            clk_lost   <= 1'b0;
        end else begin
            cnt        <= rise ? 13'd1 : (st == MEAS && cnt != LOSS) ? cnt + 13'd1 : cnt;
            period_vld <= rpt;
            period     <= rpt ? cnt : period;
            freq_ok    <= rpt ? in_rng : lose ? 1'b0 : freq_ok;
            freq_err   <= (rpt && !in_rng) || (freq_err && !clr);
            clk_lost   <= lose || (clk_lost && !clr);
        end
    end

`ifdef CLK_MON_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= freq_err | clk_lost;
    end
`endif
endmodule

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 Parameter EXP_CYC, default 1024, is the nominal mon_clk period in clk cycles.
REQ-002 Parameter TOL, default 8, is the allowed +/- deviation from EXP_CYC, in clk cycles.
REQ-003 Parameter LOSS_CYC, default 4096, is the number of clk cycles without a mon_clk rising edge that declares clock loss.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mon_clk  in  1  slow clock under test, asynchronous to clk.
REQ-007 clr  in  1  single-cycle pulse that clears the sticky flags.
REQ-008 period  out  13  last measured mon_clk period, in clk cycles.
REQ-009 period_vld  out  1  one-cycle pulse when period updates.
REQ-010 freq_ok  out  1  last period is within EXP_CYC +/- TOL and the clock is not lost.
REQ-011 freq_err  out  1  sticky flag: at least one out-of-range period was measured.
REQ-012 clk_lost  out  1  sticky flag: LOSS_CYC was reached without an edge.

Function
REQ-013 mon_clk shall pass through a 2-flop synchronizer (s1, s2) and a history flop s3; a rising edge (rise) is s2=1 and s3=0.
REQ-014 rise shall be seen by the FSM 2 cycles after the clk edge at which s1 first captures 1; period_vld shall pulse on the cycle after that.
REQ-015 The FSM shall have three states: IDLE, MEAS and LOST.
REQ-016 IDLE: on rise, go to MEAS and load cnt=1; no period is reported.
REQ-017 MEAS: cnt shall increment by 1 every cycle; saturating at LOSS_CYC is the only permitted stop.
REQ-018 MEAS on rise: load period with cnt, pulse period_vld, reload cnt=1, stay in MEAS.
REQ-019 With mon_clk = clk divided by 1024, period shall read 1024.
REQ-020 On period update, freq_ok shall be set to (|cnt - EXP_CYC| <= TOL), with the comparison done in signed 14-bit arithmetic; an out-of-range value shall set freq_err.
REQ-021 MEAS with cnt = LOSS_CYC and no rise: go to LOST, set clk_lost, clear freq_ok; period keeps its value.
REQ-022 LOST: on rise, go to MEAS with cnt=1; the first period after recovery is reported on the next rise.
REQ-023 cnt reaching LOSS_CYC in the same cycle as a rise shall be treated as a rise (MEAS path).
REQ-024 clr shall clear freq_err and clk_lost on the next cycle; if a set event occurs in the same cycle, the set wins.
REQ-025 clr shall not affect period, freq_ok, cnt or the state.

Reset
REQ-026 While rst=1 on a clk edge: state=IDLE, cnt=0, s1=s2=s3=0, period=0, period_vld=0, freq_ok=0, freq_err=0, clk_lost=0.
REQ-027 Reset asserted mid-measurement shall abort the measurement; the first rise after reset shall behave as the IDLE case (no period reported).

Configuration
REQ-028 With macro CLK_MON_IRQ_EN defined, the block shall add output irq (1 bit), registered as freq_err OR clk_lost; irq is 0 in reset and deasserts the cycle after clr clears both flags.
REQ-029 Without CLK_MON_IRQ_EN, the irq port and its register shall be absent; all other behaviour is identical.

Verification
REQ-030 mon_clk = clk/1024 for 5 periods -> period_vld pulses every 1024 cycles starting from the second rise; period=1024; freq_ok=1; freq_err=0.
REQ-031 One period stretched to 1040 -> period=1040, freq_ok=0, freq_err=1; the next 1024 period -> freq_ok=1 while freq_err stays 1.
REQ-032 mon_clk held low after a rise -> clk_lost=1 and freq_ok=0 once cnt reaches 4096; period unchanged; restarting at /1024 -> first period_vld on the second rise, value 1024.
REQ-033 clr pulsed in the same cycle as a freq_err set -> freq_err=1; clr alone later -> freq_err=0 one cycle later; irq follows when CLK_MON_IRQ_EN is defined.
REQ-034 rst pulsed at cnt=500 -> all outputs 0; the next rise reports nothing; the following rise reports 1024.
REQ-035 Period of 1016 and of 1032 (boundary values) -> freq_ok=1; period of 1015 -> freq_ok=0.
